tri_st_add_sel: RTL and testbench

- Final select stage of the split carry-select adder.
- Consumes per-byte-lane conditional sums (sum_0 = sum assuming lane carry-in 0, sum_1 = sum assuming lane carry-in 1) and per-lane group generate/transmit from the 8-bit local adders.
- Resolves the inter-lane carries, selects each lane's sum and returns the full-width result plus carry-out.
- Two registered pipeline stages with a valid/ready handshake; sits between the local lane adders and the result bus.

---
 rtl/tri_st_add_pkg.sv | 23 ++
 rtl/tri_st_add_carry.sv | 45 ++++
 rtl/tri_st_add_sel.sv | 139 +++++++++++++
 tb/tb_tri_st_add_sel.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tri_st_add_pkg.sv
// Shared lane width, lane type and the group generate/transmit merge used by the
// carry-select adder's lane-carry prefix network.
package tri_st_add_pkg;

    localparam int unsigned LANE_W = 8;

    typedef logic [0:LANE_W-1] lane_t;

    // Group generate/transmit pair for a span of lanes.
    typedef struct packed {
        logic g;
        logic t;
    } gt_t;

    // Merge a more significant span (hi) with the adjacent less significant span (lo).
    function automatic gt_t lane_prefix(input gt_t hi, input gt_t lo);
        gt_t r;
        r.g = hi.g | (hi.t & lo.g);
        r.t = hi.t & lo.t;
        return r;
    endfunction

endpackage

// File: rtl/tri_st_add_carry.sv
// Log-depth (Kogge-Stone) lane-carry resolution: lane g/t plus carry-in -> carry
// into every lane and carry out of lane 0. Lane 0 is the most significant lane.
module tri_st_add_carry
    import tri_st_add_pkg::*;
#(
    parameter int unsigned BYTES = 8
) (
    input  logic [0:BYTES-1] g,
    input  logic [0:BYTES-1] t,
    input  logic             cin,
    output logic [0:BYTES-1] c,
    output logic             cout
);

    localparam int unsigned N  = BYTES + 1;
    localparam int unsigned LV = $clog2(N);

    // Position 0 is the carry-in as a pseudo-lane; position k is lane BYTES-k.
    gt_t cur [N];
    gt_t nxt [N];

    always_comb begin : p_prefix
        cur[0].g = cin;
        cur[0].t = 1'b0;
        for (int k = 1; k < int'(N); k++) begin
            cur[k].g = g[BYTES-k];
            cur[k].t = t[BYTES-k];
        end
        nxt = cur;
        for (int lv = 0; lv < int'(LV); lv++) begin
            nxt = cur;
            for (int k = (1 << lv); k < int'(N); k++) begin
                nxt[k] = lane_prefix(cur[k], cur[k-(1 << lv)]);
            end
            cur = nxt;
        end
        // cur[k].g is now the carry out of position k.
        c = '0;
        for (int i = 0; i < int'(BYTES); i++) begin
            c[i] = cur[BYTES-1-i].g;
        end
        cout = cur[BYTES].g;
    end

endmodule

// File: rtl/tri_st_add_sel.sv
// Final select stage of the split carry-select adder: two-stage valid/ready pipe.
// Optional result-zero flag enabled by defining TRI_ST_ADD_SEL_ZERO_EN.
module tri_st_add_sel
    import tri_st_add_pkg::*;
#(
    parameter int unsigned BYTES = 8,
    localparam int unsigned W = LANE_W * BYTES
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             flush,
    input  logic             in_vld,
    output logic             in_rdy,
    input  logic [0:W-1]     in_sum_0,
    input  logic [0:W-1]     in_sum_1,
    input  logic [0:BYTES-1] in_g,
    input  logic [0:BYTES-1] in_t,
    input  logic             in_cin,
    output logic             out_vld,
    input  logic             out_rdy,
    output logic [0:W-1]     out_res,
    output logic             out_cout
`ifdef TRI_ST_ADD_SEL_ZERO_EN
    ,
    output logic             out_zero
`endif
);

    logic             s1_vld;
    logic             s2_vld;
    logic             s1_vld_nxt;
    logic             s2_vld_nxt;
    logic             s1_load;
    logic             s2_load;
    logic             s2_en;

    logic [0:W-1]     s1_sum0;
    logic [0:W-1]     s1_sum1;
    logic [0:BYTES-1] s1_g;
    logic [0:BYTES-1] s1_t;
    logic             s1_cin;

    logic [0:BYTES-1] lane_c;
    logic             cout_nxt;
    logic [0:W-1]     res_nxt;

    // Handshake and valid bookkeeping; flush kills both stages.
    always_comb begin : p_ctrl
        s2_load    = s1_vld & (~s2_vld | out_rdy);
        in_rdy     = ~flush & (~s1_vld | s2_load);
        s1_load    = in_vld & in_rdy;
        s2_en      = s2_load & ~flush;
        s1_vld_nxt = 1'b0;
        s2_vld_nxt = 1'b0;
        if (!flush) begin
            s1_vld_nxt = s1_load | (s1_vld & ~s2_load);
            s2_vld_nxt = s2_load | (s2_vld & ~out_rdy);
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin : p_vld_reg
        if (!rst_b) begin
            s1_vld <= 1'b0;
            s2_vld <= 1'b0;
        end else begin
            s1_vld <= s1_vld_nxt;
            s2_vld <= s2_vld_nxt;
        end
    end

    assign out_vld = s2_vld;

    always_ff @(posedge clk or negedge rst_b) begin : p_s1_reg
        if (!rst_b) begin
            s1_sum0 <= '0;
            s1_sum1 <= '0;
            s1_g    <= '0;
            s1_t    <= '0;
            s1_cin  <= 1'b0;
        end else if (s1_load) begin
            s1_sum0 <= in_sum_0;
            s1_sum1 <= in_sum_1;
            s1_g    <= in_g;
            s1_t    <= in_t;
            s1_cin  <= in_cin;
        end
    end

    tri_st_add_carry #(
        .BYTES (BYTES)
    ) u_carry (
        .g    (s1_g),
        .t    (s1_t),
        .cin  (s1_cin),
        .c    (lane_c),
        .cout (cout_nxt)
    );

    // Per-lane select between the two conditional sums.
    always_comb begin : p_select
        res_nxt = '0;
        for (int i = 0; i < int'(BYTES); i++) begin
            res_nxt[i*LANE_W +: LANE_W] = lane_c[i] ? lane_t'(s1_sum1[i*LANE_W +: LANE_W])
                                                    : lane_t'(s1_sum0[i*LANE_W +: LANE_W]);
        end
    end

`ifdef TRI_ST_ADD_SEL_ZERO_EN
    logic zero_nxt;

    // Lane zero flags come from the conditional sums so the mux adds no depth.
    always_comb begin : p_zero
        zero_nxt = 1'b1;
        for (int i = 0; i < int'(BYTES); i++) begin
            zero_nxt = zero_nxt & (lane_c[i] ? ~|s1_sum1[i*LANE_W +: LANE_W]
                                             : ~|s1_sum0[i*LANE_W +: LANE_W]);
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin : p_zero_reg
        if (!rst_b) begin
            out_zero <= 1'b0;
        end else if (s2_en) begin
            out_zero <= zero_nxt;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_b) begin : p_s2_reg
        if (!rst_b) begin
            out_res  <= '0;
            out_cout <= 1'b0;
        end else if (s2_en) begin
            out_res  <= res_nxt;
            out_cout <= cout_nxt;
        end
    end

endmodule

// File: tb/tb_tri_st_add_sel.sv
// Directed and random checks of tri_st_add_sel (BYTES=8); zero flag checked when
// TRI_ST_ADD_SEL_ZERO_EN is defined.
module tb_tri_st_add_sel;

    localparam int unsigned BYTES = 8;
    localparam int unsigned W     = 64;

    logic             clk = 1'b0;
    logic             rst_b;
    logic             flush;
    logic             in_vld;
    logic             in_rdy;
    logic [0:W-1]     in_sum_0;
    logic [0:W-1]     in_sum_1;
    logic [0:BYTES-1] in_g;
    logic [0:BYTES-1] in_t;
    logic             in_cin;
    logic             out_vld;
    logic             out_rdy;
    logic [0:W-1]     out_res;
    logic             out_cout;
`ifdef TRI_ST_ADD_SEL_ZERO_EN
    logic             out_zero;
`endif

    int checks = 0;
    int errors = 0;

    logic [63:0] bp_a [4];
    logic [63:0] bp_b [4];
    logic        bp_cin [4];
    logic [63:0] bp_exp [4];
    logic        bp_cout [4];
    logic [63:0] got_res [4];
    logic        got_cout [4];

    always #5 clk = ~clk;

    tri_st_add_sel #(.BYTES(BYTES)) dut (
        .clk      (clk),
        .rst_b    (rst_b),
        .flush    (flush),
        .in_vld   (in_vld),
        .in_rdy   (in_rdy),
        .in_sum_0 (in_sum_0),
        .in_sum_1 (in_sum_1),
        .in_g     (in_g),
        .in_t     (in_t),
        .in_cin   (in_cin),
        .out_vld  (out_vld),
        .out_rdy  (out_rdy),
        .out_res  (out_res),
        .out_cout (out_cout)
`ifdef TRI_ST_ADD_SEL_ZERO_EN
        ,
        .out_zero (out_zero)
`endif
    );

    // Model of the 8-bit local lane adders feeding the select stage.
    task automatic set_op(input logic [63:0] a, input logic [63:0] b, input logic cin);
        logic [8:0] s0;
        logic [8:0] s1;
        for (int i = 0; i < int'(BYTES); i++) begin
            s0 = {1'b0, a[63-8*i -: 8]} + {1'b0, b[63-8*i -: 8]};
            s1 = s0 + 9'd1;
            in_sum_0[8*i +: 8] = s0[7:0];
            in_sum_1[8*i +: 8] = s1[7:0];
            in_g[i] = s0[8];
            in_t[i] = s1[8];
        end
        in_cin = cin;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_b = 1'b0; flush = 1'b0; in_vld = 1'b0; out_rdy = 1'b0;
        set_op(64'h0, 64'h0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        checks++; if (out_vld !== 1'b0) begin errors++; $display("FAIL reset_vld got %b exp 0", out_vld); end
        checks++; if (out_res !== 64'h0) begin errors++; $display("FAIL reset_res got %h exp 0", out_res); end
        checks++; if (out_cout !== 1'b0) begin errors++; $display("FAIL reset_cout got %b exp 0", out_cout); end
        checks++; if (in_rdy !== 1'b1) begin errors++; $display("FAIL reset_in_rdy got %b exp 1", in_rdy); end
`ifdef TRI_ST_ADD_SEL_ZERO_EN
        checks++; if (out_zero !== 1'b0) begin errors++; $display("FAIL reset_zero got %b exp 0", out_zero); end
`endif
        @(negedge clk);
        rst_b = 1'b1;
        tick();
    endtask

    task automatic test_ripple();
        set_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1);
        in_vld = 1'b1; out_rdy = 1'b1;
        #1;
        checks++; if (in_rdy !== 1'b1) begin errors++; $display("FAIL ripple_in_rdy got %b exp 1", in_rdy); end
        tick();
        in_vld = 1'b0;
        checks++; if (out_vld !== 1'b0) begin errors++; $display("FAIL ripple_lat1 got %b exp 0", out_vld); end
        tick();
        checks++; if (out_vld !== 1'b1) begin errors++; $display("FAIL ripple_lat2 got %b exp 1", out_vld); end
        checks++; if (out_res !== 64'h0) begin errors++; $display("FAIL ripple_res got %h exp 0", out_res); end
        checks++; if (out_cout !== 1'b1) begin errors++; $display("FAIL ripple_cout got %b exp 1", out_cout); end
`ifdef TRI_ST_ADD_SEL_ZERO_EN
        checks++; if (out_zero !== 1'b1) begin errors++; $display("FAIL ripple_zero got %b exp 1", out_zero); end
`endif
        tick();
        checks++; if (out_vld !== 1'b0) begin errors++; $display("FAIL ripple_drain got %b exp 0", out_vld); end
    endtask

    task automatic test_mixed();
        set_op(64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b0);
        in_vld = 1'b1; out_rdy = 1'b1;
        tick();
        set_op(64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b1);
        tick();
        in_vld = 1'b0;
        checks++; if (out_vld !== 1'b1) begin errors++; $display("FAIL mixed0_vld got %b exp 1", out_vld); end
        checks++; if (out_res !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL mixed0_res got %h exp ffffffffffffffff", out_res); end
        checks++; if (out_cout !== 1'b0) begin errors++; $display("FAIL mixed0_cout got %b exp 0", out_cout); end
`ifdef TRI_ST_ADD_SEL_ZERO_EN
        checks++; if (out_zero !== 1'b0) begin errors++; $display("FAIL mixed0_zero got %b exp 0", out_zero); end
`endif
        tick();
        checks++; if (out_vld !== 1'b1) begin errors++; $display("FAIL mixed1_vld got %b exp 1", out_vld); end
        checks++; if (out_res !== 64'h0) begin errors++; $display("FAIL mixed1_res got %h exp 0", out_res); end
        checks++; if (out_cout !== 1'b1) begin errors++; $display("FAIL mixed1_cout got %b exp 1", out_cout); end
`ifdef TRI_ST_ADD_SEL_ZERO_EN
        checks++; if (out_zero !== 1'b1) begin errors++; $display("FAIL mixed1_zero got %b exp 1", out_zero); end
`endif
        tick();
        checks++; if (out_vld !== 1'b0) begin errors++; $display("FAIL mixed_drain got %b exp 0", out_vld); end
    endtask

    task automatic test_back_to_back();
        int idx;
        int got;
        bp_a[0] = 64'h0000_0000_0000_00FF; bp_b[0] = 64'h1;                   bp_cin[0] = 1'b0;
        bp_exp[0] = 64'h0000_0000_0000_0100; bp_cout[0] = 1'b0;
        bp_a[1] = 64'h8000_0000_0000_0000; bp_b[1] = 64'h8000_0000_0000_0000; bp_cin[1] = 1'b0;
        bp_exp[1] = 64'h0; bp_cout[1] = 1'b1;
        bp_a[2] = 64'h1111_1111_1111_1111; bp_b[2] = 64'h2222_2222_2222_2222; bp_cin[2] = 1'b1;
        bp_exp[2] = 64'h3333_3333_3333_3334; bp_cout[2] = 1'b0;
        bp_a[3] = 64'h00FF_00FF_00FF_00FF; bp_b[3] = 64'h0001_0001_0001_0001; bp_cin[3] = 1'b0;
        bp_exp[3] = 64'h0100_0100_0100_0100; bp_cout[3] = 1'b0;
        idx = 0;
        got = 0;
        for (int n = 0; n < 30 && got < 4; n++) begin
            out_rdy = (n >= 7);
            if (idx < 4) begin
                set_op(bp_a[idx], bp_b[idx], bp_cin[idx]);
                in_vld = 1'b1;
            end else begin
                in_vld = 1'b0;
            end
            #1;
            if (out_vld && out_rdy) begin
                got_res[got] = out_res;
                got_cout[got] = out_cout;
                got++;
            end
            if (out_vld && !out_rdy) begin
                checks++;
                if (out_res !== bp_exp[0] || out_cout !== bp_cout[0]) begin
                    errors++; $display("FAIL bp_hold got %h/%b exp %h/%b", out_res, out_cout, bp_exp[0], bp_cout[0]);
                end
            end
            if (!out_rdy && idx == 2) begin
                checks++; if (in_rdy !== 1'b0) begin errors++; $display("FAIL bp_in_rdy got %b exp 0", in_rdy); end
            end
            if (in_vld && in_rdy) idx++;
            tick();
        end
        in_vld = 1'b0;
        checks++; if (got != 4) begin errors++; $display("FAIL bp_count got %0d exp 4", got); end
        for (int k = 0; k < 4; k++) begin
            if (k < got) begin
                checks++;
                if (got_res[k] !== bp_exp[k] || got_cout[k] !== bp_cout[k]) begin
                    errors++; $display("FAIL bp_order[%0d] got %h/%b exp %h/%b", k, got_res[k], got_cout[k], bp_exp[k], bp_cout[k]);
                end
            end
        end
        checks++; if (out_vld !== 1'b0) begin errors++; $display("FAIL bp_no_dup got %b exp 0", out_vld); end
    endtask

    task automatic test_flush();
        out_rdy = 1'b0;
        set_op(64'h1, 64'h2, 1'b0);
        in_vld = 1'b1;
        tick();
        set_op(64'h5, 64'h6, 1'b0);
        tick();
        checks++; if (out_vld !== 1'b1) begin errors++; $display("FAIL flush_pre got %b exp 1", out_vld); end
        flush = 1'b1;
        set_op(64'h7, 64'h8, 1'b0);
        #1;
        checks++; if (in_rdy !== 1'b0) begin errors++; $display("FAIL flush_in_rdy got %b exp 0", in_rdy); end
        tick();
        flush = 1'b0; in_vld = 1'b0; out_rdy = 1'b1;
        checks++; if (out_vld !== 1'b0) begin errors++; $display("FAIL flush_kill0 got %b exp 0", out_vld); end
        tick();
        checks++; if (out_vld !== 1'b0) begin errors++; $display("FAIL flush_kill1 got %b exp 0", out_vld); end
        tick();
        checks++; if (out_vld !== 1'b0) begin errors++; $display("FAIL flush_kill2 got %b exp 0", out_vld); end
        set_op(64'h0000_0000_FFFF_FFFF, 64'h1, 1'b0);
        in_vld = 1'b1;
        tick();
        in_vld = 1'b0;
        tick();
        checks++; if (out_vld !== 1'b1) begin errors++; $display("FAIL flush_next_vld got %b exp 1", out_vld); end
        checks++; if (out_res !== 64'h0000_0001_0000_0000) begin errors++; $display("FAIL flush_next_res got %h exp 0000000100000000", out_res); end
        checks++; if (out_cout !== 1'b0) begin errors++; $display("FAIL flush_next_cout got %b exp 0", out_cout); end
        tick();
    endtask

    task automatic test_reset_mid();
        out_rdy = 1'b0;
        set_op(64'h1, 64'h1, 1'b0);
        in_vld = 1'b1;
        tick();
        set_op(64'h2, 64'h2, 1'b1);
        tick();
        in_vld = 1'b0;
        checks++; if (out_vld !== 1'b1 || out_res !== 64'h2) begin errors++; $display("FAIL rstmid_pre got %b/%h exp 1/2", out_vld, out_res); end
        #2;
        rst_b = 1'b0;
        #1;
        checks++; if (out_vld !== 1'b0) begin errors++; $display("FAIL rstmid_vld got %b exp 0", out_vld); end
        checks++; if (out_res !== 64'h0) begin errors++; $display("FAIL rstmid_res got %h exp 0", out_res); end
        checks++; if (out_cout !== 1'b0) begin errors++; $display("FAIL rstmid_cout got %b exp 0", out_cout); end
        @(negedge clk);
        rst_b = 1'b1;
        tick();
        out_rdy = 1'b1;
        checks++; if (out_vld !== 1'b0) begin errors++; $display("FAIL rstmid_dropped got %b exp 0", out_vld); end
        set_op(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0);
        in_vld = 1'b1;
        tick();
        in_vld = 1'b0;
        checks++; if (out_vld !== 1'b0) begin errors++; $display("FAIL rstmid_lat1 got %b exp 0", out_vld); end
        tick();
        checks++; if (out_vld !== 1'b1) begin errors++; $display("FAIL rstmid_lat2 got %b exp 1", out_vld); end
        checks++; if (out_res !== 64'h8000_0000_0000_0000) begin errors++; $display("FAIL rstmid_res2 got %h exp 8000000000000000", out_res); end
        checks++; if (out_cout !== 1'b0) begin errors++; $display("FAIL rstmid_cout2 got %b exp 0", out_cout); end
        tick();
    endtask

    task automatic test_random();
        logic [64:0] sb[$];
        logic [64:0] e;
        logic [63:0] pa;
        logic [63:0] pb;
        logic        pc;
        logic        pend;
        int          sent;
        int          cyc;
        pend = 1'b0;
        sent = 0;
        cyc  = 0;
        while ((sent < 1000 || sb.size() != 0) && cyc < 20000) begin
            if (!pend && sent < 1000 && $urandom_range(0, 3) != 0) begin
                pa = {$urandom(), $urandom()};
                pb = ($urandom_range(0, 3) == 0) ? ~pa : {$urandom(), $urandom()};
                pc = 1'($urandom_range(0, 1));
                pend = 1'b1;
            end
            if (pend) set_op(pa, pb, pc);
            in_vld = pend;
            out_rdy = ($urandom_range(0, 3) != 0);
            #1;
            if (out_vld && out_rdy) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++; $display("FAIL rand_unexpected got %h/%b exp none", out_res, out_cout);
                end else begin
                    e = sb.pop_front();
                    if (out_res !== e[63:0] || out_cout !== e[64]) begin
                        errors++; $display("FAIL rand_res got %h/%b exp %h/%b", out_res, out_cout, e[63:0], e[64]);
                    end
`ifdef TRI_ST_ADD_SEL_ZERO_EN
                    if (out_zero !== (e[63:0] == 64'h0)) begin
                        errors++; $display("FAIL rand_zero got %b exp %b", out_zero, (e[63:0] == 64'h0));
                    end
`endif
                end
            end
            if (in_vld && in_rdy) begin
                sb.push_back({1'b0, pa} + {1'b0, pb} + 65'(pc));
                sent++;
                pend = 1'b0;
            end
            tick();
            cyc++;
        end
        in_vld = 1'b0;
        checks++;
        if (sent != 1000 || sb.size() != 0) begin
            errors++; $display("FAIL rand_timeout got %0d sent %0d pending exp 1000 sent 0 pending", sent, sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_ripple();
        test_mixed();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
